mux41_rr_arbiter: RTL
=====================

# mux41_rr_arbiter

Round-robin arbiter that shares one 4:1 multiplexer path between four requesters. It owns the mux select, grants the path to one requester at a time, holds the grant until release or timeout, and registers the selected data lane. It sits in front of the existing 4:1 mux datapath as its sequencing and sharing controller.

## Interface
- W, default 1: data width of each input lane and of y.
- MAX_HOLD, default 8: maximum grant length in cycles, legal range 0..255; 0 disables the timeout.

Ports, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req  input  4  request per requester; bit k is requester k.
- done  input  1  the current owner releases the path; ignored when no grant is active.
- i  input  4*W  packed data lanes; lane k is i[k*W +: W].
- gnt  output  4  one-hot grant; all zeros when idle.
- s  output  2  mux select, equal to the index of the current owner.
- busy  output  1  high while a grant is active (gnt != 0).
- y  output  W  registered copy of the selected lane.

## Operation
- State machine states:
  - IDLE: gnt=0, busy=0.
  - GRANT: exactly one gnt bit set, busy=1.
- Priority pointer ptr (2 bits): the search for a winner starts at ptr and wraps k = ptr, ptr+1, ... mod 4. The first k with req[k]=1 wins.
- IDLE with req != 0: pick the winner, then load gnt=onehot(k), s=k, clear the hold counter, and go to GRANT.
- GRANT: a release occurs on any of these conditions:
  - done=1;
  - req[s]=0;
  - MAX_HOLD != 0 and hold counter == MAX_HOLD-1.
- On release:
  - set ptr = s+1 mod 4 (2-bit wrap);
  - re-arbitrate on the same edge using that ptr;
  - if any req is set, grant the winner directly with no idle bubble and clear the counter;
  - otherwise go to IDLE, with gnt=0 and s holding its last value.
- Re-grant of the same owner: the releasing owner can win again only if no other requester is asserted, because it is searched last.
- Hold counter: 8-bit; increments each GRANT cycle without release; saturates at 255 when MAX_HOLD=0.
- y: each edge, y = lane s of i when the next state is GRANT, otherwise 0.
- req changes during a grant never alter s except through a release.

## Timing
- Reset values (asynchronous, while rst_n=0): gnt=0, s=0, busy=0, y=0, ptr=0, counter=0, state IDLE.
- Reset mid-grant drops gnt and busy immediately, without waiting for an edge.
- Grant latency: req sampled at edge n gives gnt/s/busy valid after edge n. The selected lane appears on y after edge n+1, one cycle behind s.
- Release latency: done or req drop sampled at edge m updates gnt after edge m. Back-to-back handover costs zero idle cycles.
- Timeout: an uninterrupted grant lasts exactly MAX_HOLD cycles. MAX_HOLD=1 forces rotation every cycle when several requesters are active.
- A simultaneous done=1 and timeout is a single release; ptr advances once.
- done=1 while in IDLE has no effect.

## Test plan
- Reset, then req=4'b0100 at edge 1: gnt=4'b0100, s=2 after edge 1, busy=1; with i lane2 = 1, y=1 after edge 2.
- req=4'b1111 held, done pulsed every 3 cycles: grants rotate 0,1,2,3,0 with no idle cycle between owners.
- MAX_HOLD=8, req=4'b0011 held, done=0: requester 0 holds for exactly 8 cycles, then requester 1 takes over for 8 cycles, then requester 0 again.
- Owner 3 drops req with no other request: gnt=0 and busy=0 next edge, s stays 3, y=0; then req=4'b1001 grants 0 (ptr wrapped to 0).
- rst_n pulsed low mid-grant: gnt, busy, y and s go to 0 immediately; first grant after release follows ptr=0.
- MAX_HOLD=0, single requester held for 300 cycles: grant never drops and the counter saturates with no wrap-induced release.

Source files
------------

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 mux path.
// One requester holds the path until it signals done, drops its request,
// or hits the hold timeout. Handover to the next requester costs no idle
// cycle, and the selected lane is registered onto y.
module mux41_rr_arbiter #(
  parameter int unsigned W        = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic           done,
  input  logic [4*W-1:0] i,
  output logic [3:0]     gnt,
  output logic [1:0]     s,
  output logic           busy,
  output logic [W-1:0]   y
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A MAX_HOLD of 0 wraps HOLD_LAST to 8'hFF, but TIMEOUT_EN masks it off.
  localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);

  state_t       state_q, state_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [1:0]   s_q, s_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [W-1:0] y_q, y_d;

  logic         rel;
  logic [1:0]   search_base;
  logic         found;
  logic [1:0]   win;
  logic [W-1:0] lane_sel;

  // Lane currently addressed by the select; y lags s by one cycle.
  always_comb begin
    lane_sel = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (s_q == 2'(k)) lane_sel = i[k*W +: W];
    end
  end

  // Release detection and round-robin search. On release the search starts
  // just past the releasing owner, so it is considered last.
  always_comb begin
    rel = (state_q == GRANT) &&
          (done || !req[s_q] || (TIMEOUT_EN && (cnt_q == HOLD_LAST)));
    search_base = rel ? (s_q + 2'd1) : ptr_q;
    found = 1'b0;
    win   = '0;
    for (int unsigned off = 0; off < 4; off++) begin
      if (!found && req[search_base + 2'(off)]) begin
        found = 1'b1;
        win   = search_base + 2'(off);
      end
    end
  end

  // Next-state, grant, pointer, hold counter and registered lane.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'(1) << win;
          s_d     = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = s_q + 2'd1;
          cnt_d = '0;
          if (found) begin
            gnt_d = 4'(1) << win;
            s_d   = win;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    y_d = (state_d == GRANT) ? lane_sel : '0;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign gnt  = gnt_q;
  assign s    = s_q;
  assign busy = (state_q == GRANT);
  assign y    = y_q;

endmodule
